// File: rtl/data_cal_pkg.sv
// data_cal_pkg: constants and types shared between data_cal and its downstream result stages.
//   DW        - width of a data_cal result (its `out` port)
//   cal_res_t - one data_cal result
//   DROP_W    - width of the saturating overflow-drop counter
//   ptr_w()   - width of a FIFO pointer or occupancy value for a given depth
package data_cal_pkg;

  localparam int DW     = 5;
  localparam int DROP_W = 8;

  typedef logic [DW-1:0] cal_res_t;

  // Pointers carry one extra wrap bit beyond the address bits. This lets full and empty be told
  // apart without a separate occupancy register.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: up-counter that sticks at all-ones.
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset, clears the count
//   i_clr   - synchronous clear; has priority over i_inc
//   i_inc   - increment request; ignored once the count is all-ones
//   o_cnt   - current count
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cal_result_fifo.sv
// cal_result_fifo: first-word-fall-through result buffer behind data_cal.
// data_cal produces results with no back-pressure. This block buffers them for a consumer
// that may stall. It also counts results lost to overflow and keeps a running sum of the
// results it accepts.
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   clr       - synchronous clear of pointers, drop count and sum; wins over push/pop/drop
//   validin   - result strobe (data_cal validout)
//   din       - result (data_cal out)
//   out_ready - consumer ready
//   out_valid - head entry available
//   out_data  - head entry, combinational from memory
//   full      - occupancy == DEPTH
//   empty     - occupancy == 0
//   count     - occupancy
//   drop_cnt  - results discarded because the FIFO was full; saturates at all-ones
//   sum       - sum of accepted results, modulo 2^SW
module cal_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = data_cal_pkg::DW,
  parameter int unsigned SW    = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              validin,
  input  logic [DW-1:0]                     din,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [DW-1:0]                     out_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            count,
  output logic [data_cal_pkg::DROP_W-1:0]   drop_cnt,
  output logic [SW-1:0]                     sum
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [SW-1:0] r_sum;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // The pointers are equal when the FIFO is empty. When it is full they differ only in the
  // wrap bit.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_pop  = !w_empty && out_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign w_push = validin && (!w_full || w_pop);
  assign w_drop = validin && w_full && !w_pop;

  // Storage has no reset. Its contents reach the outputs only through out_data, and nothing
  // in the control path reads out_data.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= '0;
    end else if (w_push) begin
      r_sum <= r_sum + SW'(din);
    end
  end

  sat_cnt #(
    .W (data_cal_pkg::DROP_W)
  ) u_drop_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (clr),
    .i_inc   (w_drop),
    .o_cnt   (drop_cnt)
  );

  assign out_data  = r_mem[r_rptr[AW-1:0]];
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_wptr - r_rptr;
  assign sum       = r_sum;

endmodule

// File: tb/tb_cal_result_fifo.sv
// Bench for cal_result_fifo. A queue model tracks contents, drops and the running sum. Every
// output is compared against it on each falling clock edge. Directed sequences add literal
// expectations at the points of interest.
module tb_cal_result_fifo;
  import data_cal_pkg::*;

  localparam int DEPTH = 4;
  localparam int SWID  = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr;
  logic           validin;
  cal_res_t       din;
  logic           out_ready;
  logic           out_valid;
  cal_res_t       out_data;
  logic           full;
  logic           empty;
  logic [2:0]     count;
  logic [7:0]     drop_cnt;
  logic [11:0]    sum;

  int checks = 0;
  int errors = 0;

  cal_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .SW    (SWID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .validin   (validin),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue, drop counter and sum.
  int m_q[$];
  int m_drop = 0;
  int m_sum  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_drop = 0;
      m_sum  = 0;
    end else if (clr) begin
      m_q.delete();
      m_drop = 0;
      m_sum  = 0;
    end else begin
      bit was_full;
      bit popping;
      was_full = (m_q.size() == DEPTH);
      popping  = (m_q.size() > 0) && out_ready;
      if (popping) void'(m_q.pop_front());
      if (validin) begin
        if (!was_full || popping) begin
          m_q.push_back(int'(din));
          m_sum = (m_sum + int'(din)) % 4096;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("sum", 32'(sum), 32'(m_sum));
    if (m_q.size() > 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int drain_exp[4] = '{2, 3, 4, 9};

  initial begin
    clr = 1'b0; validin = 1'b0; din = '0; out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_sum", 32'(sum), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Three pushes held, then drained in order.
    validin = 1'b1; din = 5'd5; tick();
    din = 5'd3; tick();
    din = 5'd7; tick();
    validin = 1'b0;
    chk("t1_count", 32'(count), 3);
    chk("t1_sum", 32'(sum), 15);
    chk("t1_head", 32'(out_data), 5);
    out_ready = 1'b1;
    tick(); chk("t1_drain1", 32'(out_data), 3);
    tick(); chk("t1_drain2", 32'(out_data), 7);
    tick(); chk("t1_empty", 32'(empty), 1);
    out_ready = 1'b0;

    // Overflow: six pushes into four entries.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t2_clr_sum", 32'(sum), 0);
    for (int v = 1; v <= 6; v++) begin
      validin = 1'b1; din = 5'(v); tick();
      if (v == 3) chk("t2_not_full", 32'(full), 0);
      if (v == 4) chk("t2_full", 32'(full), 1);
    end
    validin = 1'b0;
    chk("t2_drop", 32'(drop_cnt), 2);
    chk("t2_sum", 32'(sum), 10);
    chk("t2_head", 32'(out_data), 1);

    // Push into a full FIFO with a simultaneous pop.
    validin = 1'b1; din = 5'd9; out_ready = 1'b1; tick();
    validin = 1'b0; out_ready = 1'b0;
    chk("t3_count", 32'(count), 4);
    chk("t3_drop", 32'(drop_cnt), 2);
    chk("t3_sum", 32'(sum), 19);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", 32'(out_data), 32'(drain_exp[i]));
      tick();
    end
    chk("t3_empty", 32'(empty), 1);
    out_ready = 1'b0;

    // Drop-counter saturation, then clear racing a push.
    for (int v = 0; v < 4; v++) begin
      validin = 1'b1; din = 5'(20 + v); tick();
    end
    din = 5'd1;
    repeat (300) tick();
    chk("t4_sat", 32'(drop_cnt), 255);
    tick();
    chk("t4_sat_hold", 32'(drop_cnt), 255);
    clr = 1'b1; din = 5'd5; tick();
    clr = 1'b0; validin = 1'b0;
    chk("t4_clr_count", 32'(count), 0);
    chk("t4_clr_drop", 32'(drop_cnt), 0);
    chk("t4_clr_sum", 32'(sum), 0);

    // Sustained one-per-cycle input with continuous drain; sum wraps.
    out_ready = 1'b1; validin = 1'b1; din = 5'd31;
    repeat (140) tick();
    validin = 1'b0;
    chk("t5_sum", 32'(sum), 244);
    chk("t5_drop", 32'(drop_cnt), 0);
    tick();
    chk("t5_empty", 32'(empty), 1);
    out_ready = 1'b0;

    // Asynchronous reset with two entries held.
    validin = 1'b1; din = 5'd10; tick();
    din = 5'd11; tick();
    validin = 1'b0;
    chk("t6_count", 32'(count), 2);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_sum", 32'(sum), 0);
    chk("t6_rst_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    rst = 1'b1; validin = 1'b1; din = 5'd17;
    tick();
    validin = 1'b0;
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_data", 32'(out_data), 17);
    chk("t6_sum", 32'(sum), 17);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
